// File: rtl/dmem_arb_pkg.sv
// Shared types and limits for the data-memory port arbiter (dmem_arbiter, rr_pick).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        GRANT = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_CPU = 2'd0;
    localparam int         MAX_N_DMA = 4;
    localparam int         CNT_W     = 8;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping upward.
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [1:0]   idx,
    output logic         valid
);

    // Scan by distance from ptr so every bit select uses a constant index.
    always_comb begin
        // NOTE: every output gets a default first, so no path through this block infers a latch.
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int d = 0; d < N; d++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid && req[i] && (((i + N - int'(ptr)) % N) == d)) begin
                    valid  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Registered CPU/DMA arbiter for the data-memory port; HOLD/HOLD_ACK handshake with round-robin.
// Optional burst limit compiled in with `define DMEM_ARB_BURST_LIMIT_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N_DMA     = 2,
    parameter int MAX_BURST = 16,
    parameter int DW        = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_we,
    input  logic [DW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wd,
    input  logic [N_DMA-1:0]    dma_hold,
    input  logic [N_DMA-1:0]    dma_we,
    input  logic [N_DMA*DW-1:0] dma_addr,
    input  logic [N_DMA*DW-1:0] dma_wd,
    output logic [N_DMA-1:0]    dma_ack,
    output logic                cpu_stall,
    output logic [1:0]          owner,
    output logic                dmem_we,
    output logic [DW-1:0]       dmem_addr,
    output logic [DW-1:0]       dmem_wd
);

    if (N_DMA < 1 || N_DMA > MAX_N_DMA) begin : g_bad_n_dma
        $error("dmem_arbiter: N_DMA must be 1..4");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("dmem_arbiter: MAX_BURST must be 1..255");
    end

    arb_state_t       state, state_nxt;
    logic [N_DMA-1:0] ack_q, ack_nxt;
    logic [1:0]       gnt_idx, gnt_idx_nxt;
    logic [1:0]       rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic [N_DMA-1:0] pick_gnt;
    logic [1:0]       pick_idx;
    logic             pick_valid;
    logic             burst_expire;

    rr_pick #(.N(N_DMA)) u_rr_pick (
        .req   (dma_hold),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef DMEM_ARB_BURST_LIMIT_EN
    // Counter holds completed grant cycles, so expiry on the MAX_BURST-th cycle.
    assign burst_expire = (burst_cnt >= CNT_W'(MAX_BURST - 1));
`else
    assign burst_expire = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        ack_nxt       = ack_q;
        gnt_idx_nxt   = gnt_idx;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt     = GRANT;
                    ack_nxt       = pick_gnt;
                    gnt_idx_nxt   = pick_idx;
                    burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (burst_cnt != {CNT_W{1'b1}}) burst_cnt_nxt = burst_cnt + 1'b1;
                if (!(|(dma_hold & ack_q)) || burst_expire) begin
                    state_nxt  = GAP;
                    ack_nxt    = '0;
                    rr_ptr_nxt = (gnt_idx == 2'(N_DMA - 1)) ? 2'd0 : gnt_idx + 2'd1;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ack_q     <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ack_q     <= ack_nxt;
            gnt_idx   <= gnt_idx_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    assign dma_ack   = ack_q;
    assign cpu_stall = |ack_q;
    // Decoded from flops only; with N_DMA = 4 master 3 aliases to 0, so the mux keys off dma_ack.
    assign owner     = cpu_stall ? gnt_idx + 2'd1 : OWNER_CPU;

    always_comb begin
        dmem_we   = cpu_we;
        dmem_addr = cpu_addr;
        dmem_wd   = cpu_wd;
        if (cpu_stall) begin
            dmem_we   = 1'b0;
            dmem_addr = '0;
            dmem_wd   = '0;
            for (int i = 0; i < N_DMA; i++) begin
                if (ack_q[i]) begin
                    dmem_we   = dma_we[i];
                    dmem_addr = dma_addr[i*DW +: DW];
                    dmem_wd   = dma_wd[i*DW +: DW];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter; burst-limit scenario follows DMEM_ARB_BURST_LIMIT_EN.
module tb_dmem_arbiter;

    localparam int N  = 2;
    localparam int MB = 4;
    localparam int DW = 32;
`ifdef DMEM_ARB_BURST_LIMIT_EN
    localparam int S2_LEN = MB;
`else
    localparam int S2_LEN = 5;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_we = 1'b0;
    logic [DW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wd = '0;
    logic [N-1:0]  dma_hold = '0;
    logic [N-1:0]  dma_we = '0;
    logic [N*DW-1:0] dma_addr = '0;
    logic [N*DW-1:0] dma_wd = '0;
    logic [N-1:0]  dma_ack;
    logic          cpu_stall;
    logic [1:0]    owner;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wd;

    dmem_arbiter #(.N_DMA(N), .MAX_BURST(MB), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wd    (cpu_wd),
        .dma_hold  (dma_hold),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wd    (dma_wd),
        .dma_ack   (dma_ack),
        .cpu_stall (cpu_stall),
        .owner     (owner),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wd   (dmem_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  ack;
        logic [1:0]    own;
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected output after the next edge, mux result taken from the inputs now driven.
    task automatic tick(input logic [N-1:0] ack);
        exp_t e;
        exp_t o;
        e.ack = ack;
        e.own = ack[0] ? 2'd1 : (ack[1] ? 2'd2 : 2'd0);
        case (e.own)
            2'd1:    begin e.we = dma_we[0]; e.addr = dma_addr[31:0];  e.wd = dma_wd[31:0];  end
            2'd2:    begin e.we = dma_we[1]; e.addr = dma_addr[63:32]; e.wd = dma_wd[63:32]; end
            default: begin e.we = cpu_we;    e.addr = cpu_addr;        e.wd = cpu_wd;        end
        endcase
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("ack",   64'(dma_ack),   64'(o.ack));
        check("stall", 64'(cpu_stall), 64'(|o.ack));
        check("owner", 64'(owner),     64'(o.own));
        check("we",    64'(dmem_we),   64'(o.we));
        check("addr",  64'(dmem_addr), 64'(o.addr));
        check("wd",    64'(dmem_wd),   64'(o.wd));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with both masters requesting.
        dma_hold = 2'b11;
        cpu_addr = 32'h40;
        #1 rst = 1'b0;
        #1;
        check("rst_ack",   64'(dma_ack),   64'h0);
        check("rst_owner", 64'(owner),     64'h0);
        check("rst_stall", 64'(cpu_stall), 64'h0);
        check("rst_addr",  64'(dmem_addr), 64'h40);
        @(posedge clk);
        #1;
        check("rst_hold_ack", 64'(dma_ack), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(2'b01);
        dma_hold = 2'b00;
        tick(2'b00);
        tick(2'b00);

        // Master 0 writes 0xA5 to 0x100; CPU and master 1 writes must not leak through.
        cpu_we   = 1'b1;
        cpu_addr = 32'h200;
        cpu_wd   = 32'h1234;
        dma_we   = 2'b11;
        dma_addr = {32'h0000_BAD0, 32'h0000_0100};
        dma_wd   = {32'hDEAD_BEEF, 32'h0000_00A5};
        dma_hold = 2'b01;
        repeat (S2_LEN) tick(2'b01);
        dma_hold = 2'b00;
        tick(2'b00);
        tick(2'b00);

        // Reset in the third grant cycle; rr_ptr is 1 here, so reset must clear it.
        cpu_we   = 1'b0;
        dma_we   = 2'b01;
        dma_hold = 2'b01;
        repeat (3) tick(2'b01);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ack",   64'(dma_ack),   64'h0);
        check("mid_rst_stall", 64'(cpu_stall), 64'h0);
        check("mid_rst_owner", 64'(owner),     64'h0);
        check("mid_rst_addr",  64'(dmem_addr), 64'(cpu_addr));
        @(negedge clk);
        dma_hold = 2'b00;
        rst = 1'b1;
        tick(2'b00);

        // Both masters hold continuously.
        dma_hold = 2'b11;
`ifdef DMEM_ARB_BURST_LIMIT_EN
        for (int r = 0; r < 3; r++) begin
            repeat (MB) tick((r % 2 == 1) ? 2'b10 : 2'b01);
            if (r == 2) dma_hold = 2'b00;
            repeat (2) tick(2'b00);
        end
`else
        repeat (8) tick(2'b01);
        dma_hold = 2'b10;
        tick(2'b00);
        tick(2'b00);
        tick(2'b10);
        dma_hold = 2'b00;
        tick(2'b00);
        tick(2'b00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
